// File: rtl/pip_reg_skid.sv
// Elastic valid/ready pipeline stage built on a two-entry skid buffer, with flush and occupancy.
// Optional statistics counters are compiled in when PIP_REG_STATS_EN is defined.
module pip_reg_skid #(
  parameter int unsigned PAYLOAD_WIDTH = 64,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic [1:0]               occupancy,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                   state;
  logic [PAYLOAD_WIDTH-1:0] main_q;
  logic [PAYLOAD_WIDTH-1:0] skid_q;
  logic                     in_fire_c;
  logic                     out_fire_c;

  assign in_fire_c   = in_valid & in_ready;
  assign out_fire_c  = out_valid & out_ready;
  assign out_payload = main_q;

  // Handshake flags and occupancy are registered alongside the state so they leave the stage glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire_c) begin
            state     <= ONE;
            main_q    <= in_payload;
            out_valid <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        ONE: begin
          if (in_fire_c && out_fire_c) begin
            main_q <= in_payload;
          end else if (in_fire_c) begin
            // Downstream stalled: park the new payload behind M.
            state     <= FULL;
            skid_q    <= in_payload;
            in_ready  <= 1'b0;
            occupancy <= 2'd2;
          end else if (out_fire_c) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
          end
        end
        FULL: begin
          if (out_fire_c) begin
            state     <= ONE;
            main_q    <= skid_q;
            in_ready  <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

`ifdef PIP_REG_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Saturating stall and effective-flush counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (flush && occupancy != 2'd0 && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pip_reg_skid.sv
// Self-checking bench for pip_reg_skid: directed vector table, corner sequences, and random traffic vs a queue model.
module tb_pip_reg_skid;

  localparam int unsigned PW = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0] in_payload, out_payload;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: a FIFO of held payloads plus the last payload that sat at the head.
  logic [PW-1:0] mq[$];
  logic [PW-1:0] last_front;
  int            m_stall, m_flush;

  pip_reg_skid #(.PAYLOAD_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic f, input logic iv,
                            input logic [PW-1:0] ip, input logic ordy);
    bit ifire, ofire;
    if (!r) begin
      mq.delete();
      last_front = '0;
      m_stall = 0;
      m_flush = 0;
      return;
    end
    ifire = iv && (mq.size() < 2);
    ofire = (mq.size() > 0) && ordy;
    if (mq.size() > 0 && !ordy && m_stall < (1 << CW) - 1) m_stall++;
    if (f && mq.size() > 0 && m_flush < (1 << CW) - 1) m_flush++;
    if (f) begin
      mq.delete();
    end else begin
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back(ip);
    end
    if (mq.size() > 0) last_front = mq[0];
  endtask

  task automatic check_model();
    check("in_ready", int'(in_ready), int'(mq.size() < 2));
    check("out_valid", int'(out_valid), int'(mq.size() > 0));
    check("occupancy", int'(occupancy), mq.size());
    check("out_payload", int'(out_payload), int'(last_front));
`ifdef PIP_REG_STATS_EN
    check("stall_cnt", int'(stall_cnt), m_stall);
    check("flush_cnt", int'(flush_cnt), m_flush);
`else
    check("stall_cnt", int'(stall_cnt), 0);
    check("flush_cnt", int'(flush_cnt), 0);
`endif
  endtask

  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [PW-1:0] ip, input logic ordy);
    rst_n = r; flush = f; in_valid = iv; in_payload = ip; out_ready = ordy;
    model_step(r, f, iv, ip, ordy);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic          r, f, iv;
    logic [PW-1:0] ip;
    logic          ordy;
    logic          e_ir, e_ov;
    logic [1:0]    e_occ;
    logic [PW-1:0] e_pl;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [PW-1:0] ip, logic ordy,
                              logic e_ir, logic e_ov, logic [1:0] e_occ, logic [PW-1:0] e_pl);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.ip = ip; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ; v.e_pl = e_pl;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_payload = '0; out_ready = 1'b0;
    last_front = '0; m_stall = 0; m_flush = 0;

    // Reset, stream, backpressure A/B/C, flush when empty, flush when full, reset when full.
    vt.push_back(mk(0,0,0,16'h00,0, 1,0,0,16'h00));
    vt.push_back(mk(0,0,0,16'h00,0, 1,0,0,16'h00));
    vt.push_back(mk(1,0,1,16'h01,1, 1,1,1,16'h01));
    vt.push_back(mk(1,0,1,16'h02,1, 1,1,1,16'h02));
    vt.push_back(mk(1,0,1,16'h03,1, 1,1,1,16'h03));
    vt.push_back(mk(1,0,1,16'h0A,1, 1,1,1,16'h0A));
    vt.push_back(mk(1,0,1,16'h0B,0, 0,1,2,16'h0A));
    vt.push_back(mk(1,0,1,16'h0C,0, 0,1,2,16'h0A));
    vt.push_back(mk(1,0,1,16'h0C,1, 1,1,1,16'h0B));
    vt.push_back(mk(1,0,1,16'h0C,0, 0,1,2,16'h0B));
    vt.push_back(mk(1,0,0,16'h00,1, 1,1,1,16'h0C));
    vt.push_back(mk(1,0,0,16'h00,1, 1,0,0,16'h0C));
    vt.push_back(mk(1,1,0,16'h00,0, 1,0,0,16'h0C));
    vt.push_back(mk(1,0,1,16'h11,0, 1,1,1,16'h11));
    vt.push_back(mk(1,0,1,16'h12,0, 0,1,2,16'h11));
    vt.push_back(mk(1,1,1,16'h13,0, 1,0,0,16'h11));
    vt.push_back(mk(1,0,0,16'h00,1, 1,0,0,16'h11));
    vt.push_back(mk(1,0,1,16'h21,0, 1,1,1,16'h21));
    vt.push_back(mk(1,0,1,16'h22,0, 0,1,2,16'h21));
    vt.push_back(mk(0,0,0,16'h00,0, 1,0,0,16'h00));

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].r, vt[i].f, vt[i].iv, vt[i].ip, vt[i].ordy);
      check($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vt[i].e_ir));
      check($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vt[i].e_ov));
      check($sformatf("vec%0d_occupancy", i), int'(occupancy), int'(vt[i].e_occ));
      check($sformatf("vec%0d_out_payload", i), int'(out_payload), int'(vt[i].e_pl));
    end

    // Stage 1..8 with 1-cycle latency and occupancy held at 1.
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 0, 1, PW'(i), 1);
      check("stream_payload", int'(out_payload), i);
      check("stream_occ", int'(occupancy), 1);
    end
    cycle(1, 0, 0, '0, 1);

    // Fill to FULL, then a reset glitch between edges must not disturb state.
    cycle(1, 0, 1, 16'h31, 0);
    cycle(1, 0, 1, 16'h32, 0);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cycle(1, 0, 0, '0, 0);
    check("glitch_occ", int'(occupancy), 2);
    check("glitch_payload", int'(out_payload), 16'h31);
    cycle(1, 0, 0, '0, 1);
    check("drain_skid", int'(out_payload), 16'h32);
    cycle(1, 0, 0, '0, 1);

    // Random traffic with rare flushes and resets.
    for (int n = 0; n < 10000; n++) begin
      cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 3) != 0), PW'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pip_reg_skid.md
# pip_reg_skid

Parametrised elastic pipeline stage register that replaces the fixed, always-load inter-stage registers with a valid/ready handshaked stage. Built around a two-entry skid buffer, so upstream `in_ready` is a registered signal while the stage still sustains one transfer per cycle. Adds synchronous reset, pipeline flush and occupancy reporting. Sits between any two pipeline stages (e.g. EX→MEM, MEM→WB); the stage fields are packed into a single payload vector by the instantiating level.

## Interface
Parameters:
- `PAYLOAD_WIDTH`, 64: bit width of the packed stage payload.
- `CNT_WIDTH`, 16: width of the statistics counters.

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n` is synchronous and active-low.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous active-low reset.
- `flush`  in  1: discard all held entries and any input in the same cycle.
- `in_valid`  in  1: upstream presents a payload.
- `in_ready`  out  1: stage accepts a payload this cycle; registered.
- `in_payload`  in  PAYLOAD_WIDTH: upstream payload.
- `out_valid`  out  1: output payload is valid.
- `out_ready`  in  1: downstream accepts the output this cycle.
- `out_payload`  out  PAYLOAD_WIDTH: output payload; driven directly from the main register.
- `occupancy`  out  2: number of held entries, 0 to 2.
- `stall_cnt`  out  CNT_WIDTH: number of cycles with `out_valid & !out_ready`.
- `flush_cnt`  out  CNT_WIDTH: number of flush cycles that discarded at least one entry.

## Operation
- in_fire = `in_valid & in_ready`; out_fire = `out_valid & out_ready`.
- Storage: main register (M) drives the output; skid register (S) catches an accepted input while downstream stalls.
- States:
  - EMPTY (occupancy 0)
  - ONE (M valid)
  - FULL (M and S valid)
- `in_ready` = state != FULL.
- `out_valid` = state != EMPTY.
- Transitions (no flush):
  - EMPTY: in_fire → ONE, M←in.
  - ONE: in_fire & out_fire → ONE, M←in.
  - ONE: in_fire & !out_fire → FULL, S←in.
  - ONE: !in_fire & out_fire → EMPTY.
  - ONE: otherwise hold.
  - FULL: out_fire → ONE, M←S.
  - FULL: otherwise hold.
  - FULL: no input is accepted.
- Ordering: strict FIFO; the payload in S never overtakes M.
- Flush:
  - Next state is EMPTY, whatever the current state or handshakes.
  - A same-cycle in_fire is discarded. A same-cycle out_fire still counts as a completed transfer downstream.
  - Payload registers keep their contents; only the valid state clears. Consumers gate every field with `out_valid`.
- Priority: `rst_n` over `flush` over handshake.
- Upstream contract: `in_payload` is held stable while `in_valid & !in_ready`. The stage does not check this.
- Downstream guarantee: once asserted, `out_valid` does not drop and `out_payload` does not change until out_fire, except on flush or reset.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - state EMPTY, `in_ready`=1, `out_valid`=0, `occupancy`=0.
  - M, S and `out_payload` = 0.
  - `stall_cnt` and `flush_cnt` = 0.
- Latency: a payload accepted at edge N appears on `out_payload` with `out_valid`=1 after edge N (visible in cycle N+1), when the stage was empty or draining.
- Throughput: 1 payload per cycle while `out_ready`=1.
- Backpressure:
  - `in_ready` falls one cycle after the stall, once S is filled.
  - Exactly one extra payload is absorbed after downstream stalls.
- Recovery from FULL: after the first out_fire, `in_ready` is 1 in the next cycle.
- Flush timing: `out_valid`=0 and `in_ready`=1 in the cycle after `flush`.
- Reset mid-operation behaves identically to flush, and additionally zeroes payloads and counters.

## Configuration
- Macro: `PIP_REG_STATS_EN`.
- Defined:
  - `stall_cnt` increments every cycle with `out_valid & !out_ready`.
  - `flush_cnt` increments on each `flush` cycle while occupancy > 0.
  - Both counters saturate at all-ones and clear only on reset.
- Undefined:
  - Counter logic is not compiled.
  - `stall_cnt` and `flush_cnt` are tied to 0.
  - Ports remain present, so the interface is unchanged.

## Test plan
- Reset then stream: hold `rst_n`=0 for 2 cycles, then drive payloads 1..8 with `in_valid`=1 and `out_ready`=1 → after reset `out_valid`=0 and `in_ready`=1; outputs 1..8 on consecutive cycles with 1-cycle latency; occupancy stays 1.
- Backpressure: drop `out_ready` while streaming 0xA,0xB,0xC → 0xA held on the output; 0xB captured in S; `in_ready`=0 next cycle; 0xC held upstream. After `out_ready`=1, the order out is 0xA,0xB,0xC with no loss or duplication.
- Flush when FULL, with `in_valid`=1 in the same cycle → next cycle `out_valid`=0, occupancy 0, `in_ready`=1; the same-cycle input never appears at the output. With `PIP_REG_STATS_EN`, `flush_cnt`=1.
- Flush when EMPTY → state unchanged; `flush_cnt` unchanged.
- Random valid/ready (10k cycles) against a scoreboard → FIFO order kept; `out_payload` stable while stalled. With `PIP_REG_STATS_EN`, `stall_cnt` equals the count of stall cycles, and with CNT_WIDTH=4 it saturates at 15.
- Synchronous reset asserted when FULL, with `out_ready`=0 → after the edge: occupancy 0, `out_payload`=0, counters 0; a reset pulse that does not span a clock edge has no effect.
